// File: rtl/led_sequencer_if.sv
// led_sequencer_if: tick inputs, pattern controls and LED outputs of the LED sequencer
interface led_sequencer_if #(
  parameter int NT = 8,
  parameter int SW = 3
);
  logic [NT-1:0] tick_in;
  logic [SW-1:0] sel;
  logic [1:0]    mode;
  logic          run;
  logic [7:0]    leds;
  logic          step;
  logic          wrap;
  modport master (output tick_in, sel, mode, run, input leds, step, wrap);
  modport slave  (input tick_in, sel, mode, run, output leds, step, wrap);
endinterface

// File: rtl/led_sequencer.sv
// led_sequencer: steps an 8-LED pattern on rising edges of a selected, synchronised tick
module led_sequencer #(
  parameter int NT = 8,
  parameter int SW = 3
) (
  input logic           clk_in,
  input logic           rstn,
  led_sequencer_if.slave bus
);
  localparam int NP = 1 << SW;
  localparam logic [1:0] SHIFT = 2'd0, BOUNCE = 2'd1, COUNT = 2'd2;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state, state_d;
  logic [NT-1:0] s1, s2, prev;
  logic [NP-1:0] rise_p;
  logic tick_edge;
  logic [7:0] leds_q, leds_d, adv;
  logic [1:0] mode_q, mode_d;
  logic dir, dir_d, adv_dir, adv_wrap;
  logic step_q, step_d, wrap_q, wrap_d;
  function automatic logic [7:0] seed(input logic [1:0] m);
    return m[1] ? 8'h00 : 8'h01;
  endfunction
  always_ff @(posedge clk_in or negedge rstn)
    if (!rstn) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= bus.tick_in;
      s2   <= s1;
      prev <= s2;
    end
  // zero padding makes out-of-range selects read as no edge
  assign rise_p    = NP'(s2 & ~prev);
  assign tick_edge = rise_p[bus.sel];
  // dir: 0 = up (towards bit 7), 1 = down
  always_comb begin
    adv      = mode_q == SHIFT  ? {leds_q[6:0], leds_q[7]} :
               mode_q == BOUNCE ? (dir ? leds_q >> 1 : leds_q << 1) :
               mode_q == COUNT  ? leds_q + 8'd1 : ~leds_q;
    adv_wrap = mode_q == SHIFT  ? leds_q == 8'h80 :
               mode_q == BOUNCE ? dir && leds_q == 8'h02 : leds_q == 8'hFF;
    adv_dir  = mode_q != BOUNCE ? dir :
               dir ? leds_q != 8'h02 : leds_q == 8'h40;
  end
  always_comb begin
    state_d = state;
    leds_d  = leds_q;
    mode_d  = mode_q;
    dir_d   = dir;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state)
      IDLE: if (bus.run) begin
        state_d = RUN;
        leds_d  = seed(bus.mode);
        mode_d  = bus.mode;
        dir_d   = 1'b0;
      end
      RUN: if (!bus.run) state_d = HOLD;
      else if (tick_edge) begin
        step_d = 1'b1;
        leds_d = bus.mode != mode_q ? seed(bus.mode) : adv;
        mode_d = bus.mode;
        dir_d  = bus.mode != mode_q ? 1'b0 : adv_dir;
        wrap_d = bus.mode == mode_q && adv_wrap;
      end
      HOLD: if (bus.run) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rstn)
    if (!rstn) begin
      state  <= IDLE;
      leds_q <= 8'h00;
      mode_q <= 2'd0;
      dir    <= 1'b0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_d;
      leds_q <= leds_d;
      mode_q <= mode_d;
      dir    <= dir_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  assign bus.leds = leds_q;
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: scoreboard bench checking LED patterns, step/wrap pulses, latency and reset
module tb_led_sequencer;
  logic clk_in = 1'b0;
  logic rstn = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [8:0] q[$];
  logic [8:0] e_mon;
  led_sequencer_if #(.NT(8), .SW(3)) bus();
  led_sequencer #(.NT(8), .SW(3)) dut (.clk_in(clk_in), .rstn(rstn), .bus(bus));
  always #5 clk_in = ~clk_in;
  // every step pops one expected {leds, wrap}; steps nobody expected are errors
  always @(negedge clk_in) begin
    if (bus.step) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step leds=%h wrap=%b", bus.leds, bus.wrap);
      end else begin
        e_mon = q.pop_front();
        if ({bus.leds, bus.wrap} !== e_mon) begin
          errors++;
          $display("FAIL step_value got leds=%h wrap=%b want leds=%h wrap=%b", bus.leds, bus.wrap, e_mon[8:1], e_mon[0]);
        end
      end
    end else if (bus.wrap) begin
      checks++;
      errors++;
      $display("FAIL wrap_without_step leds=%h", bus.leds);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  task automatic pulse(input int i);
    @(posedge clk_in) #1 bus.tick_in[i] = 1'b1;
    repeat (4) @(posedge clk_in);
    #1 bus.tick_in[i] = 1'b0;
    repeat (4) @(posedge clk_in);
  endtask
  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    repeat (6) @(negedge clk_in);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_steps got %0d outstanding want 0", name, q.size());
      q.delete();
    end
  endtask
  task automatic check_leds(input string name, input logic [7:0] want);
    #1;
    checks++;
    if (bus.leds !== want) begin
      errors++;
      $display("FAIL %s leds got %h want %h", name, bus.leds, want);
    end
  endtask
  task automatic test_reset;
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({bus.leds, bus.step, bus.wrap} !== 10'h000) begin
      errors++;
      $display("FAIL reset_state got leds=%h step=%b wrap=%b want 00 0 0", bus.leds, bus.step, bus.wrap);
    end
    repeat (3) @(posedge clk_in);
    @(negedge clk_in) rstn = 1'b1;
    repeat (2) @(posedge clk_in);
    check_leds("idle_no_run", 8'h00);
    @(posedge clk_in) #1 bus.run = 1'b1;
    repeat (2) @(posedge clk_in);
    check_leds("shift_seed", 8'h01);
  endtask
  task automatic test_shift;
    q.push_back({8'h02, 1'b0});
    @(posedge clk_in) #1 bus.tick_in[0] = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++;
    if (bus.step !== 1'b0) begin
      errors++;
      $display("FAIL latency_early step got %b want 0", bus.step);
    end
    @(negedge clk_in);
    checks++;
    if (bus.step !== 1'b1) begin
      errors++;
      $display("FAIL latency_n2 step got %b want 1", bus.step);
    end
    @(negedge clk_in);
    checks++;
    if (bus.step !== 1'b0) begin
      errors++;
      $display("FAIL step_width step got %b want 0", bus.step);
    end
    #1 bus.tick_in[0] = 1'b0;
    repeat (4) @(posedge clk_in);
    for (int k = 2; k <= 8; k++) begin
      q.push_back({8'(1 << (k % 8)), k == 8});
      pulse(0);
    end
    drain("shift");
  endtask
  task automatic test_bounce;
    @(posedge clk_in) #1 bus.mode = 2'd1;
    q.push_back({8'h01, 1'b0});
    pulse(0);
    for (int k = 1; k <= 15; k++) begin
      q.push_back({8'(k <= 7 ? 1 << k : k <= 14 ? 1 << (14 - k) : 2), k == 14});
      pulse(0);
    end
    drain("bounce");
  endtask
  task automatic test_count;
    @(posedge clk_in) #1 bus.mode = 2'd2;
    q.push_back({8'h00, 1'b0});
    pulse(0);
    for (int k = 1; k <= 256; k++) begin
      q.push_back({8'(k % 256), k == 256});
      pulse(0);
    end
    drain("count");
    q.push_back({8'h01, 1'b0});
    @(posedge clk_in) #1 bus.tick_in[0] = 1'b1;
    repeat (50) @(posedge clk_in);
    #1 bus.tick_in[0] = 1'b0;
    repeat (4) @(posedge clk_in);
    drain("held_tick");
  endtask
  task automatic test_sel_switch;
    @(posedge clk_in) #1 bus.sel = 3'd3;
    bus.tick_in[3] = 1'b0;
    repeat (4) @(posedge clk_in);
    #1 bus.tick_in[0] = 1'b1;
    repeat (6) @(posedge clk_in);
    #1 bus.sel = 3'd0;
    repeat (10) @(posedge clk_in);
    check_leds("sel_switch", 8'h01);
    pulse(3);
    drain("unselected_edge");
    check_leds("unselected_leds", 8'h01);
    @(posedge clk_in) #1 bus.tick_in[0] = 1'b0;
    repeat (4) @(posedge clk_in);
  endtask
  task automatic test_hold;
    @(posedge clk_in) #1 bus.mode = 2'd0;
    q.push_back({8'h01, 1'b0});
    pulse(0);
    q.push_back({8'h02, 1'b0});
    pulse(0);
    q.push_back({8'h04, 1'b0});
    pulse(0);
    drain("pre_hold");
    @(posedge clk_in) #1 bus.run = 1'b0;
    repeat (2) @(posedge clk_in);
    for (int k = 0; k < 5; k++) pulse(0);
    drain("hold_no_step");
    check_leds("hold_frozen", 8'h04);
    @(posedge clk_in) #1 bus.run = 1'b1;
    repeat (2) @(posedge clk_in);
    q.push_back({8'h08, 1'b0});
    pulse(0);
    @(posedge clk_in) #1 bus.mode = 2'd3;
    q.push_back({8'h00, 1'b0});
    pulse(0);
    q.push_back({8'hFF, 1'b0});
    pulse(0);
    q.push_back({8'h00, 1'b1});
    pulse(0);
    drain("resume_blink");
  endtask
  task automatic test_reset_mid;
    @(posedge clk_in) #1 bus.mode = 2'd0;
    q.push_back({8'h01, 1'b0});
    pulse(0);
    for (int k = 1; k <= 4; k++) begin
      q.push_back({8'(1 << k), 1'b0});
      pulse(0);
    end
    drain("pre_reset");
    q.push_back({8'h20, 1'b0});
    @(posedge clk_in) #1 bus.tick_in[0] = 1'b1;
    repeat (3) @(posedge clk_in);
    #2;
    checks++;
    if ({bus.leds, bus.step} !== {8'h20, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset_step got leds=%h step=%b want 20 1", bus.leds, bus.step);
    end
    q.delete();
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.leds, bus.step, bus.wrap} !== 10'h000) begin
      errors++;
      $display("FAIL async_reset got leds=%h step=%b wrap=%b want 00 0 0", bus.leds, bus.step, bus.wrap);
    end
    bus.tick_in[0] = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in) rstn = 1'b1;
    repeat (3) @(posedge clk_in);
    check_leds("reseed", 8'h01);
    q.push_back({8'h02, 1'b0});
    pulse(0);
    drain("post_reset");
  endtask
  initial begin
    bus.tick_in = '0;
    bus.sel = '0;
    bus.mode = 2'd0;
    bus.run = 1'b0;
    test_reset();
    test_shift();
    test_bounce();
    test_count();
    test_sel_switch();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
